// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory-to-memory copy engine: default bus widths
// and the FSM state encoding used by mem_copy_dma.
package mem_copy_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_dma_if.sv
// Single-port word memory bus shared by the copy engine (master) and the
// memory it drives (slave). read_data is combinational from address/MemRead.
interface mem_copy_dma_if
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              MemRead;
    logic              MemWrite;

    modport master (
        output address,
        output write_data,
        output MemRead,
        output MemWrite,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  MemRead,
        input  MemWrite,
        output read_data
    );

endinterface

// File: rtl/data_mem.sv
// Small word-addressed memory used as the copy engine's responder.
// The bus address is folded modulo the depth, so wide pointers simply alias.
// Reads are combinational so data is valid in the same cycle as MemRead.
// load/peek form a side port for preloading and inspecting contents.
module data_mem
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH_W = 6
) (
    input  logic               CLK,
    input  logic               load_en,
    input  logic [DEPTH_W-1:0] load_addr,
    input  logic [DATA_W-1:0]  load_data,
    input  logic [DEPTH_W-1:0] peek_addr,
    output logic [DATA_W-1:0]  peek_data,
    mem_copy_dma_if.slave      mem
);

    localparam int DEPTH = 1 << DEPTH_W;

    logic [DATA_W-1:0]  ram [DEPTH];
    logic [DEPTH_W-1:0] bus_idx;

    assign bus_idx       = DEPTH_W'(mem.address % ADDR_W'(DEPTH));
    assign mem.read_data = mem.MemRead ? ram[bus_idx] : '0;
    assign peek_data     = ram[peek_addr];

    // Bus writes take priority over side-port loads
    always_ff @(posedge CLK) begin
        if (mem.MemWrite) begin
            ram[bus_idx] <= mem.write_data;
        end else if (load_en) begin
            ram[load_addr] <= load_data;
        end
    end

endmodule

// File: rtl/mem_copy_dma.sv
// Memory copy engine: copies `length` words from src_addr to dst_addr,
// one read cycle then one write cycle per word, ascending addresses,
// pointers wrapping modulo 2^ADDR_W. Overlapping regions copy forward.
// Optional feature macro: MEM_COPY_CHECKSUM_EN adds a `checksum` output with
// the modulo-2^DATA_W sum of every word written in the current transfer.
module mem_copy_dma
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    mem_copy_dma_if.master    mem
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t            state_reg;
    logic [ADDR_W-1:0] src_ptr_reg;
    logic [ADDR_W-1:0] dst_ptr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  words_done_reg;
    logic [LEN_W-1:0]  words_inc;
    logic              busy_reg;
    logic              done_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;

    assign words_inc = words_done_reg + 1'b1;

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign words_done     = words_done_reg;
    assign mem.address    = addr_reg;
    assign mem.write_data = wdata_reg;
    assign mem.MemRead    = mem_read_reg;
    assign mem.MemWrite   = mem_write_reg;

    // FSM plus datapath; strobes and bus values are set on the transition into
    // each state, so they are registered and only one strobe is ever high.
    // wdata_reg doubles as the word buffer between READ and WRITE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= IDLE;
            src_ptr_reg    <= '0;
            dst_ptr_reg    <= '0;
            len_reg        <= '0;
            words_done_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        words_done_reg <= '0;
                        if (length != '0) begin
                            src_ptr_reg  <= src_addr;
                            dst_ptr_reg  <= dst_addr;
                            len_reg      <= length;
                            addr_reg     <= src_addr;
                            mem_read_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                            state_reg    <= READ;
                        end else begin
                            // Empty transfer: report completion without touching memory
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                READ: begin
                    wdata_reg     <= mem.read_data;
                    addr_reg      <= dst_ptr_reg;
                    src_ptr_reg   <= src_ptr_reg + 1'b1;
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b1;
                    state_reg     <= WRITE;
                end
                WRITE: begin
                    mem_write_reg  <= 1'b0;
                    dst_ptr_reg    <= dst_ptr_reg + 1'b1;
                    words_done_reg <= words_inc;
                    if (words_inc == len_reg) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        addr_reg     <= src_ptr_reg;
                        mem_read_reg <= 1'b1;
                        state_reg    <= READ;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg;

    assign checksum = checksum_reg;

    // Running sum of words as they are written; restarts on any accepted start
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            checksum_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            checksum_reg <= '0;
        end else if (state_reg == WRITE) begin
            checksum_reg <= checksum_reg + wdata_reg;
        end
    end
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma with data_mem as the responder.
// Stimulus pushes expected reads, writes and completions into queues; a
// negedge monitor pops and compares whenever the bus or done is active.
module tb_mem_copy_dma;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 16;
    localparam int DEPTH_W = 6;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  words_done;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif
    logic               load_en;
    logic [DEPTH_W-1:0] load_addr;
    logic [DATA_W-1:0]  load_data;
    logic [DEPTH_W-1:0] peek_addr;
    logic [DATA_W-1:0]  peek_data;

    always #5 CLK = ~CLK;

    mem_copy_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    mem_copy_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .mem        (mem_bus)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    data_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) u_mem (
        .CLK       (CLK),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .peek_addr (peek_addr),
        .peek_data (peek_data),
        .mem       (mem_bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        int                lat;
        logic [LEN_W-1:0]  wd;
        logic [DATA_W-1:0] cks;
    } done_t;

    logic [ADDR_W-1:0] exp_rd[$];
    wr_t               exp_wr[$];
    done_t             exp_done[$];
    logic [DATA_W-1:0] model [64];

    int  compared   = 0;
    int  mismatched = 0;
    time start_t    = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: event with nothing expected", name);
    endfunction

    logic [ADDR_W-1:0] mon_ra;
    wr_t               mon_w;
    done_t             mon_d;
    int                mon_lat;

    // Monitor: compare every bus strobe and completion against the scoreboard
    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if (mem_bus.MemRead || mem_bus.MemWrite)
                check("rd_wr_exclusive", {mem_bus.MemRead, mem_bus.MemWrite} == 2'b11, 0);
            if (mem_bus.MemRead) begin
                if (exp_rd.size() == 0) fail_now("unexpected_read");
                else begin
                    mon_ra = exp_rd.pop_front();
                    $display("txn read  addr=0x%08h", mem_bus.address);
                    check("read_addr", mem_bus.address, mon_ra);
                end
            end
            if (mem_bus.MemWrite) begin
                if (exp_wr.size() == 0) fail_now("unexpected_write");
                else begin
                    mon_w = exp_wr.pop_front();
                    $display("txn write addr=0x%08h data=0x%08h", mem_bus.address,
                             mem_bus.write_data);
                    check("write_addr", mem_bus.address, mon_w.addr);
                    check("write_data", mem_bus.write_data, mon_w.data);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) fail_now("unexpected_done");
                else begin
                    mon_d   = exp_done.pop_front();
                    mon_lat = int'(($time - start_t + 5) / 10);
                    $display("txn done  words=%0d latency=%0d", words_done, mon_lat);
                    check("done_latency", mon_lat, mon_d.lat);
                    check("done_words", words_done, mon_d.wd);
                    check("done_busy_low", busy, 0);
`ifdef MEM_COPY_CHECKSUM_EN
                    check("done_checksum", checksum, mon_d.cks);
`endif
                end
            end
        end
    end

    task automatic load_word(input int a, input logic [DATA_W-1:0] d);
        @(negedge CLK);
        load_en   = 1'b1;
        load_addr = DEPTH_W'(a);
        load_data = d;
        @(negedge CLK);
        load_en   = 1'b0;
        model[a]  = d;
    endtask

    task automatic peek(input int a, output logic [DATA_W-1:0] d);
        peek_addr = DEPTH_W'(a);
        #1;
        d = peek_data;
    endtask

    // Queue expectations for the first k words (and optionally completion), then pulse start
    task automatic issue(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                         input logic [LEN_W-1:0] n, input int k, input bit with_done);
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] sum;
        done_t             dn;
        wr_t               w;
        sum = '0;
        for (int i = 0; i < k; i++) begin
            ra = s + ADDR_W'(i);
            wa = d + ADDR_W'(i);
            v  = model[ra[5:0]];
            model[wa[5:0]] = v;
            sum = sum + v;
            exp_rd.push_back(ra);
            w.addr = wa;
            w.data = v;
            exp_wr.push_back(w);
        end
        if (with_done) begin
            dn.lat = 2 * int'(n) + 1;
            dn.wd  = n;
            dn.cks = sum;
            exp_done.push_back(dn);
        end
        @(negedge CLK);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = n;
        @(posedge CLK);
        start_t = $time;
        @(negedge CLK);
        start = 1'b0;
        check("busy_after_start", busy, (n != 0));
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) @(negedge CLK);
        check("reads_drained", exp_rd.size(), 0);
        check("writes_drained", exp_wr.size(), 0);
        check("dones_drained", exp_done.size(), 0);
    endtask

    logic [DATA_W-1:0] rd;

    initial begin
        RST_N     = 1'b0;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        length    = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        peek_addr = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_memread", mem_bus.MemRead, 0);
        check("rst_memwrite", mem_bus.MemWrite, 0);
        check("rst_address", mem_bus.address, 0);
        check("rst_wdata", mem_bus.write_data, 0);
        check("rst_words", words_done, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Background pattern so untouched words have known values
        for (int i = 0; i < 64; i++) load_word(i, 32'hC000_0000 + i);

        // Basic three-word copy
        load_word(1, 32'd1);
        load_word(2, 32'd2);
        load_word(3, 32'd3);
        issue(32'd1, 32'd10, 16'd3, 3, 1'b1);
        drain(10);
        peek(10, rd); check("basic_mem10", rd, 32'd1);
        peek(11, rd); check("basic_mem11", rd, 32'd2);
        peek(12, rd); check("basic_mem12", rd, 32'd3);
        check("basic_words_hold", words_done, 16'd3);
        check("basic_addr_hold", mem_bus.address, 32'd12);
        check("basic_wdata_hold", mem_bus.write_data, 32'd3);

        // Zero-length transfer: completion only, no bus activity
        issue(32'd5, 32'd20, 16'd0, 0, 1'b1);
        drain(4);
        peek(20, rd); check("zero_mem20", rd, 32'hC000_0014);
        check("zero_words", words_done, 16'd0);

        // Start pulses during a transfer must be ignored
        load_word(24, 32'h0000_00A1);
        load_word(25, 32'h0000_00A2);
        load_word(26, 32'h0000_00A3);
        load_word(27, 32'h0000_00A4);
        issue(32'd24, 32'd44, 16'd4, 4, 1'b1);
        @(negedge CLK);
        start    = 1'b1;
        src_addr = 32'd0;
        dst_addr = 32'd50;
        length   = 16'd7;
        repeat (2) @(negedge CLK);
        start = 1'b0;
        drain(12);
        peek(44, rd); check("ign_mem44", rd, 32'h0000_00A1);
        peek(47, rd); check("ign_mem47", rd, 32'h0000_00A4);
        peek(50, rd); check("ign_mem50", rd, 32'hC000_0032);

        // Overlapping forward copy replicates the first word
        issue(32'd1, 32'd2, 16'd3, 3, 1'b1);
        drain(10);
        peek(4, rd); check("overlap_mem4", rd, 32'd1);

        // Reset after the first word of a three-word copy
        issue(32'd33, 32'd53, 16'd3, 1, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_memread", mem_bus.MemRead, 0);
        check("midrst_memwrite", mem_bus.MemWrite, 0);
        check("midrst_address", mem_bus.address, 0);
        check("midrst_wdata", mem_bus.write_data, 0);
        check("midrst_words", words_done, 0);
        peek(53, rd); check("midrst_mem53", rd, 32'hC000_0021);
        peek(54, rd); check("midrst_mem54", rd, 32'hC000_0036);
        check("midrst_writes_drained", exp_wr.size(), 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Source pointer wraps from the top of the address space; also
        // the first start after reset release
        load_word(63, 32'hAAAA_0001);
        load_word(0, 32'h5555_0002);
        issue(32'hFFFF_FFFF, 32'd30, 16'd2, 2, 1'b1);
        drain(8);
        peek(30, rd); check("wrap_mem30", rd, 32'hAAAA_0001);
        peek(31, rd); check("wrap_mem31", rd, 32'h5555_0002);

`ifdef MEM_COPY_CHECKSUM_EN
        load_word(40, 32'd5);
        load_word(41, 32'd7);
        load_word(42, 32'hFFFF_FFFF);
        issue(32'd40, 32'd56, 16'd3, 3, 1'b1);
        drain(10);
        check("checksum_hold", checksum, 32'h0000_000B);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
